issue_scoreboard: RTL
=====================

Name: issue_scoreboard

Overview:
- Register scoreboard and issue controller between decode and execute in the RV32I core.
- Consumes decoded fields (opcode, rs1, rs2, rd) and tracks pending register writes.
- Stalls decode on RAW/WAW hazards, on a full in-flight window, on execute backpressure, and during a flush.
- Releases scoreboard entries when instructions retire.

Parameters:
- MAX_INFLIGHT, 4, maximum number of issued but not yet retired instructions (1..15).
- CNT_W, 4, width of the in-flight counter; must hold MAX_INFLIGHT.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- valid_id  in  1  decode stage holds a valid instruction
- opcode  in  7  instruction[6:0]
- rs1_id  in  5  source register 1
- rs2_id  in  5  source register 2
- rd_id  in  5  destination register
- ex_ready  in  1  execute stage can accept an instruction this cycle
- flush  in  1  kill the instruction in decode this cycle
- retire_valid  in  1  one instruction completes this cycle
- retire_we  in  1  the retiring instruction writes rd
- retire_rd  in  5  destination of the retiring instruction
- issue  out  1  instruction is accepted into execute this cycle (combinational)
- stall_id  out  1  valid_id & ~issue & ~flush (combinational)
- busy_vec  out  32  registered pending-write bitmap; bit 0 is always 0
- inflight  out  CNT_W  registered count of in-flight instructions
- err  out  1  sticky protocol error flag

Behaviour:
- Reset (asynchronous, rst_n=0): busy_vec=0, inflight=0, err=0. Outputs issue and stall_id are 0 because they depend on valid_id.
- Opcode classes (use_rs1 / use_rs2 / wr_rd):
  - LUI 0110111, AUIPC 0010111, JAL 1101111: 0/0/1
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011: 1/0/1
  - BRANCH 1100011, STORE 0100011: 1/1/0
  - OP 0110011: 1/1/1
  - Any other opcode: 0/0/0. It still issues and occupies an in-flight slot.
- Effective busy set eb = busy_vec, or the bypassed form when the optional feature is enabled. Register x0 is never busy.
- Hazard is asserted when any of the following holds:
  - use_rs1 & eb[rs1_id]
  - use_rs2 & eb[rs2_id]
  - wr_rd & rd_id≠0 & eb[rd_id] (WAW)
- issue = valid_id & ~flush & ex_ready & ~hazard & (inflight < MAX_INFLIGHT).
- Counter update:
  - inflight increments on issue and decrements on retire_valid.
  - If both occur in the same cycle, inflight holds.
- Busy-bit update:
  - On issue & wr_rd & rd_id≠0: set busy_vec[rd_id].
  - On retire_valid & retire_we & retire_rd≠0: clear busy_vec[retire_rd].
  - If set and clear target the same register in the same cycle, set wins (new owner).
- Error conditions (err is set and stays set until reset):
  - retire_valid while inflight==0. inflight does not underflow; it stays at 0.
  - retire_we targeting a register whose busy bit is 0. The busy bit stays 0.
- Flush:
  - Blocks issue in that cycle only.
  - busy_vec and inflight are untouched, because older instructions still retire.
- Full window: at inflight==MAX_INFLIGHT, issue is blocked unless the optional feature is enabled and a retire occurs in the same cycle.
- Latency: issue is combinational in the same cycle. busy_vec and inflight reflect the event in the following cycle.

Optional Feature:
- Macro: ISSUE_SCOREBOARD_RETIRE_BYPASS_EN
- Defined:
  - eb = busy_vec & ~(one-hot of retire_rd, gated by retire_valid & retire_we & retire_rd≠0).
  - The window test becomes (inflight - retire_valid) < MAX_INFLIGHT.
  - An instruction dependent on the retiring register issues in the retire cycle.
- Undefined:
  - eb = busy_vec and the window test uses inflight only.
  - Dependents issue one cycle after retire.

Decomposition:
- Package core_pkg holds:
  - Opcode localparams: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP.
  - A packed struct for the use_rs1/use_rs2/wr_rd class.
- Sub-module opcode_class: pure combinational opcode → class lookup, reusable by the forwarding unit.

Test Plan:
- Reset, then valid OP x3←x1,x2 with ex_ready=1 → issue=1; next cycle busy_vec=0x0000_0008, inflight=1.
- With x3 busy, valid OP-IMM x5←x3 → issue=0, stall_id=1 until the retire of rd=3.
  - Feature off: issue in the cycle after the retire.
  - Feature on: issue in the retire cycle.
- Issue 4 non-writing STOREs without retire → 5th instruction stalls with inflight=4. A retire plus a new issue in the same cycle keeps inflight=4.
- Write rd=x0 (OP x0←x1,x2) → issue=1 and busy_vec stays 0. Next instruction reading x0 issues without stall.
- flush=1 with a valid, hazard-free instruction → issue=0, stall_id=0, and busy_vec/inflight unchanged.
- retire_valid with inflight=0 → err=1 next cycle and inflight stays 0. Asserting rst_n=0 mid-stream clears busy_vec, inflight and err asynchronously.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I decode definitions: major opcodes and the register-usage class
// consumed by the issue scoreboard and the forwarding unit.
package core_pkg;

  localparam int unsigned OPC_W  = 7;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_OP     = 7'b0110011;

  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
    logic wr_rd;
  } op_class_t;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode -> register-usage class lookup.
module opcode_class
  import core_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output op_class_t        cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL:  cls = '{use_rs1: 1'b0, use_rs2: 1'b0, wr_rd: 1'b1};
      OP_JALR, OP_LOAD, OP_IMM:  cls = '{use_rs1: 1'b1, use_rs2: 1'b0, wr_rd: 1'b1};
      OP_BRANCH, OP_STORE:       cls = '{use_rs1: 1'b1, use_rs2: 1'b1, wr_rd: 1'b0};
      OP_OP:                     cls = '{use_rs1: 1'b1, use_rs2: 1'b1, wr_rd: 1'b1};
      default:                   cls = '0;
    endcase
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Register scoreboard and issue control between decode and execute.
// Define ISSUE_SCOREBOARD_RETIRE_BYPASS_EN to let same-cycle retires unblock issue.
module issue_scoreboard
  import core_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_id,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rd_id,
  input  logic             ex_ready,
  input  logic             flush,
  input  logic             retire_valid,
  input  logic             retire_we,
  input  logic [4:0]       retire_rd,
  output logic             issue,
  output logic             stall_id,
  output logic [31:0]      busy_vec,
  output logic [CNT_W-1:0] inflight,
  output logic             err
);

  localparam int unsigned CW1 = CNT_W + 1;

  op_class_t            cls;
  logic                 ret_wr;
  logic [NUM_REGS-1:0]  ret_mask;
  logic [NUM_REGS-1:0]  set_mask;
  logic [NUM_REGS-1:0]  eb;
  logic                 room;
  logic                 hazard;

  opcode_class u_opcode_class (
    .opcode (opcode),
    .cls    (cls)
  );

  assign ret_wr   = retire_valid & retire_we & (retire_rd != '0);
  assign ret_mask = ret_wr ? (NUM_REGS'(1) << retire_rd) : '0;

`ifdef ISSUE_SCOREBOARD_RETIRE_BYPASS_EN
  // Retiring register and retiring slot are already free for this cycle's issue.
  assign eb   = busy_vec & ~ret_mask & ~NUM_REGS'(1);
  assign room = {1'b0, inflight} < (CW1'(MAX_INFLIGHT) + CW1'(retire_valid));
`else
  assign eb   = busy_vec & ~NUM_REGS'(1);
  assign room = {1'b0, inflight} < CW1'(MAX_INFLIGHT);
`endif

  assign hazard = (cls.use_rs1 & eb[rs1_id])
                | (cls.use_rs2 & eb[rs2_id])
                | (cls.wr_rd & (rd_id != '0) & eb[rd_id]);

  assign issue    = valid_id & ~flush & ex_ready & ~hazard & room;
  assign stall_id = valid_id & ~issue & ~flush;
  assign set_mask = (issue & cls.wr_rd & (rd_id != '0)) ? (NUM_REGS'(1) << rd_id) : '0;

  // Clear before set so a same-cycle reallocation keeps the new owner busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= ((busy_vec & ~ret_mask) | set_mask) & ~NUM_REGS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({issue, retire_valid})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   if (inflight != '0) inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Sticky: retire with nothing in flight, or write-retire of a non-pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((retire_valid && (inflight == '0)) || (ret_wr && !busy_vec[retire_rd])) begin
      err <= 1'b1;
    end
  end

endmodule
